// File: rtl/video_info_scan.sv
// video_info_scan: sweeps the video parameter calculator's multiplexed read port
// (par_num -> par_dout, one clk_sys of read latency), reassembles the 32-bit
// quantities and publishes a snapshot only when two consecutive sweeps match
// bit-for-bit, so values torn by cross-domain updates are never shown.
// Optional build macro: VIDEO_INFO_SCAN_IRQ_EN (nres-change interrupt).
// The output field map assumes NUM_PAR >= 18.
module video_info_scan #(
  parameter int unsigned NUM_PAR   = 18,
  parameter int unsigned GAP       = 255,
  parameter int unsigned MAX_RETRY = 15
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  output logic [4:0]  par_num,
  input  logic [15:0] par_dout,
  input  logic        enable,
  output logic [31:0] hcnt,
  output logic [31:0] vcnt,
  output logic [31:0] htime,
  output logic [31:0] vtime,
  output logic [31:0] pix,
  output logic [31:0] vtime_hdmi,
  output logic [31:0] ccnt,
  output logic [7:0]  pixrep,
  output logic [15:0] de_h,
  output logic [7:0]  de_v,
  output logic [7:0]  nres,
  output logic        interlaced,
  output logic        rotated,
  output logic        valid,
  output logic        upd,
  output logic        err,
  output logic        irq,
  input  logic        irq_ack
);

  localparam int unsigned GapW   = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [4:0]        LastIdx  = 5'(NUM_PAR);
  localparam logic [GapW-1:0]   GapLast  = (GAP == 0) ? '0 : GapW'(GAP - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCheck, StGapw} state_e;

  state_e            state_q, state_d;
  logic [4:0]        par_num_q, par_num_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [RetryW-1:0] miss_q, miss_d;
  logic              err_q, err_d;
  logic              cap_en;
  logic [4:0]        cap_idx;
  logic              check;
  logic              match;
  logic              commit;

  logic [NUM_PAR:1][15:0] cap_q;
  logic [NUM_PAR:1][15:0] prev_q;
  logic [NUM_PAR:1][15:0] snap_q;
  logic                   prev_valid_q;
  logic                   valid_q;
  logic                   upd_q;

  // FSM state, sweep index and gap counter registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      par_num_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      par_num_q <= par_num_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Sweep sequencing; par_dout seen now belongs to the index issued last cycle
  always_comb begin
    state_d   = state_q;
    par_num_d = par_num_q;
    gap_cnt_d = gap_cnt_q;
    cap_en    = 1'b0;
    cap_idx   = par_num_q - 5'd1;
    check     = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d   = StIssue;
          par_num_d = 5'd1;
        end
      end
      StIssue: begin
        // Word for index 0 (issued from IDLE) is discarded
        cap_en = (par_num_q != 5'd1);
        if (par_num_q == LastIdx) begin
          par_num_d = '0;
          state_d   = StDrain;
        end else begin
          par_num_d = par_num_q + 5'd1;
        end
      end
      StDrain: begin
        cap_en  = 1'b1;
        cap_idx = LastIdx;
        state_d = StCheck;
      end
      StCheck: begin
        check     = 1'b1;
        gap_cnt_d = '0;
        state_d   = (GAP == 0) ? StIdle : StGapw;
      end
      StGapw: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign match  = prev_valid_q && (cap_q == prev_q);
  assign commit = check && match;

  // Capture buffer: one 16-bit word per parameter index
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
    end else if (cap_en) begin
      for (int unsigned i = 1; i <= NUM_PAR; i++) begin
        if (cap_idx == 5'(i)) cap_q[i] <= par_dout;
      end
    end
  end

  // Mismatch counter (saturating) and sticky error next-state
  always_comb begin
    miss_d = miss_q;
    err_d  = err_q;
    if (commit) begin
      miss_d = '0;
      err_d  = 1'b0;
    end else if (check) begin
      if (miss_q != RetryMax) miss_d = miss_q + RetryW'(1);
      if (miss_d == RetryMax) err_d = 1'b1;
    end
  end

  // Previous-sweep buffer, its validity and retry tracking
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      miss_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      miss_q <= miss_d;
      err_q  <= err_d;
      if (check) begin
        prev_q       <= cap_q;
        prev_valid_q <= 1'b1;
      end
    end
  end

  // Coherent snapshot commit with one-cycle update pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      snap_q  <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= commit;
      if (commit) begin
        snap_q  <= cap_q;
        valid_q <= 1'b1;
      end
    end
  end

`ifdef VIDEO_INFO_SCAN_IRQ_EN
  logic irq_q;
  logic irq_set;

  // The committed nres doubles as the history; !valid_q marks the first commit
  assign irq_set = commit && (!valid_q || (cap_q[1][7:0] != snap_q[1][7:0]));

  // Interrupt flag: set on nres change, cleared by ack, set wins a tie
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign irq            = 1'b0;
`endif

  // Field map: low word at the even index, high word at the odd one
  assign par_num    = par_num_q;
  assign hcnt       = {snap_q[3], snap_q[2]};
  assign vcnt       = {snap_q[5], snap_q[4]};
  assign htime      = {snap_q[7], snap_q[6]};
  assign vtime      = {snap_q[9], snap_q[8]};
  assign pix        = {snap_q[11], snap_q[10]};
  assign vtime_hdmi = {snap_q[13], snap_q[12]};
  assign ccnt       = {snap_q[15], snap_q[14]};
  assign pixrep     = snap_q[16][7:0];
  assign de_h       = snap_q[17];
  assign de_v       = snap_q[18][7:0];
  assign nres       = snap_q[1][7:0];
  assign interlaced = |snap_q[1][9:8];
  assign rotated    = snap_q[1][10];
  assign valid      = valid_q;
  assign upd        = upd_q;
  assign err        = err_q;

  // Upper bits of the narrow fields are intentionally dropped
  logic unused_snap_bits;
  assign unused_snap_bits = ^{snap_q[1][15:11], snap_q[16][15:8], snap_q[18][15:8]};

endmodule
